dino_game_ctrl: RTL
===================

DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameter TICK_INIT, 1000, initial game-step period in clk cycles (>=2).
REQ-002 Parameter TICK_MIN, 200, minimum game-step period in clk cycles (>=2, <=TICK_INIT).
REQ-003 Parameter TICK_STEP, 100, period reduction per level-up, in clk cycles.
REQ-004 Parameter LEVEL_PTS, 16, score points per level-up (>=1).
REQ-005 Parameter SCORE_W, 16, score width in bits.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 jump_button  input  1  raw, asynchronous player button; start/restart request.
REQ-009 collision  input  1  level from the dino/obstacle datapath; 1 = dino hit obstacle.
REQ-010 game_tick  output  1  registered one-cycle pulse; step enable for dino movement and obstacle shift.
REQ-011 run  output  1  1 while state is RUN.
REQ-012 game_over  output  1  1 while state is OVER.
REQ-013 score  output  SCORE_W  steps survived in current/last game, unsigned.
REQ-014 level  output  3  current speed level, 0..7.

Function
REQ-015 jump_button SHALL pass a 2-flop synchronizer; a start event is the rising edge of the synchronized signal (one cycle wide), so the state update occurs on the 3rd rising clk edge after jump_button rises.
REQ-016 FSM states SHALL be IDLE, RUN, OVER; holding jump_button high SHALL produce exactly one start event.
REQ-017 IDLE: game_tick=0; start event -> RUN, clearing score, level, tick counter, and loading period=TICK_INIT on the same edge.
REQ-018 RUN: tick counter increments every cycle; when it equals period-1 it wraps to 0 and game_tick pulses on the next cycle, giving exactly one pulse per period cycles, first pulse period cycles after RUN entry.
REQ-019 Each game_tick pulse SHALL increment score by 1, saturating at 2^SCORE_W-1 (no wrap).
REQ-020 When an increment makes score a nonzero multiple of LEVEL_PTS: level+1 (saturate at 7), period=max(period-TICK_STEP, TICK_MIN); new period takes effect from the following tick interval.
REQ-021 collision=1 in any RUN cycle -> OVER on next edge; a game_tick that would issue that cycle SHALL be suppressed and score SHALL not increment.
REQ-022 collision SHALL be ignored in IDLE and OVER.
REQ-023 OVER: game_tick=0; score and level frozen; start event -> IDLE (not directly RUN); a second start event is required to play.
REQ-024 Start events in RUN SHALL be ignored (jump itself is handled by the movement datapath).
REQ-025 run and game_over SHALL be registered decodes of state, never both 1.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, game_tick=0, run=0, game_over=0, score=0, level=0, tick counter=0, period=TICK_INIT, synchronizer flops=0, regardless of state or mid-period count.
REQ-027 Release of reset SHALL not itself create a start event even if jump_button is high (synchronizer starts at 0 and requires a low-then-high transition... first synchronized edge after release counts only if jump_button was low at release); bench checks both cases.

Verification
REQ-028 TICK_INIT=4: reset, pulse jump_button -> run=1 three edges later; game_tick pulses 4 cycles after RUN entry then every 4 cycles; score 1,2,3.
REQ-029 TICK_INIT=10, TICK_STEP=3, TICK_MIN=5, LEVEL_PTS=2: run 6 ticks -> level 1 at score 2 (period 7), level 2 at score 4 (period 5), level 3 at score 6 (period stays 5).
REQ-030 collision=1 in the cycle a tick is due at score 7 -> no pulse, score stays 7, game_over=1 next cycle, further collision/ticks no effect.
REQ-031 OVER, jump_button held high 50 cycles -> single transition to IDLE, score held 7; release and press again -> RUN, score 0, level 0.
REQ-032 Assert reset=0 mid-period in RUN with score 5 -> all outputs to reset values asynchronously, before next clk edge.
REQ-033 SCORE_W=3, no collisions -> score saturates at 7, game_tick keeps pulsing, level saturates at 7.

Source files
------------

// File: rtl/dino_game_ctrl.sv
// Game-flow controller for the dino runner: start/restart handling through a
// synchronized button, IDLE/RUN/OVER sequencing, game-step pulse generation,
// score counting and speed-level ramp.
module dino_game_ctrl #(
  parameter int unsigned TICK_INIT = 1000,
  parameter int unsigned TICK_MIN  = 200,
  parameter int unsigned TICK_STEP = 100,
  parameter int unsigned LEVEL_PTS = 16,
  parameter int unsigned SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jump_button,
  input  logic               collision,
  output logic               game_tick,
  output logic               run,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level
);

  localparam int unsigned PER_W = $clog2(TICK_INIT + 1);
  localparam int unsigned PTS_W = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state;
  logic               sync1, sync2, sync_prev;
  logic               valid1, valid2;
  logic               start;
  logic [PER_W-1:0]   cnt;
  logic [PER_W-1:0]   period;
  logic [PTS_W-1:0]   pts;

  // Button synchronizer and rising-edge detect. sync_prev is held at 1 until
  // the pipeline carries real samples, so a button already high at reset
  // release never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= jump_button;
      sync2     <= sync1;
      valid1    <= 1'b1;
      valid2    <= valid1;
      sync_prev <= valid2 ? sync2 : 1'b1;
    end
  end

  assign start = sync2 & ~sync_prev;

  // Game FSM with step timer, score, level ramp and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      game_tick <= 1'b0;
      run       <= 1'b0;
      game_over <= 1'b0;
      score     <= '0;
      level     <= '0;
      cnt       <= '0;
      period    <= PER_W'(TICK_INIT);
      pts       <= '0;
    end else begin
      game_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            run       <= 1'b1;
            game_over <= 1'b0;
            score     <= '0;
            level     <= '0;
            cnt       <= '0;
            period    <= PER_W'(TICK_INIT);
            pts       <= '0;
          end
        end
        RUN: begin
          if (collision) begin
            state     <= OVER;
            run       <= 1'b0;
            game_over <= 1'b1;
          end else if (cnt == period - PER_W'(1)) begin
            cnt       <= '0;
            game_tick <= 1'b1;
            // pts tracks score modulo LEVEL_PTS; it stops with the score at
            // saturation so no further level-ups occur.
            if (score != '1) begin
              score <= score + SCORE_W'(1);
              if (pts == PTS_W'(LEVEL_PTS - 1)) begin
                pts <= '0;
                if (level != 3'd7) begin
                  level <= level + 3'd1;
                end
                if (32'(period) >= TICK_MIN + TICK_STEP) begin
                  period <= period - PER_W'(TICK_STEP);
                end else begin
                  period <= PER_W'(TICK_MIN);
                end
              end else begin
                pts <= pts + PTS_W'(1);
              end
            end
          end else begin
            cnt <= cnt + PER_W'(1);
          end
        end
        OVER: begin
          if (start) begin
            state     <= IDLE;
            game_over <= 1'b0;
            run       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          run       <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
